// File: rtl/fast2slow_pulse_tx.sv
// fast2slow_pulse_tx: event pulses to 4-phase req level with queued replay of pending events
module fast2slow_pulse_tx #(
  parameter int SYNC_STAGES = 3,
  parameter int CNT_W       = 4
) (
  input  logic             clk_fast,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic             ack_in,
  output logic             req_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             done,
  output logic             overflow
);
  typedef enum logic [1:0] {IDLE, REQ, ACKLO} state_t;
  localparam logic [CNT_W-1:0] MAX = '1;
  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic                   ack_sync, launch, inc, dec, drop, done_nx;
  logic [CNT_W-1:0]       pending_nx;
  assign ack_sync   = sync[SYNC_STAGES-1];
  assign launch     = (state == IDLE || state == ACKLO) && !ack_sync && (pulse_in || pending != '0);
  assign dec        = launch && pending != '0;
  // a pulse launched straight from an empty queue never touches the counter
  assign inc        = pulse_in && !(launch && pending == '0);
  assign drop       = inc && !dec && pending == MAX;
  assign pending_nx = drop ? pending : pending + CNT_W'(inc) - CNT_W'(dec);
  assign done_nx    = state == ACKLO && !ack_sync;
  assign state_nx   = launch                    ? REQ   :
                      (state == REQ && ack_sync) ? ACKLO :
                      done_nx                    ? IDLE  : state;
  assign busy       = state != IDLE;
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= '0;
      state    <= IDLE;
      req_out  <= 1'b0;
      pending  <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], ack_in};
      state    <= state_nx;
      req_out  <= state_nx == REQ;
      pending  <= pending_nx;
      done     <= done_nx;
      overflow <= overflow | drop;
    end
  end
endmodule

// File: tb/tb_fast2slow_pulse_tx.sv
// tb_fast2slow_pulse_tx: directed stimulus with a done-driven scoreboard of {pending, req_out}
module tb_fast2slow_pulse_tx;
  logic       clk = 1'b0;
  logic       rst_n, pulse_in, ack_in, req_out, busy, done, overflow;
  logic [1:0] pending;
  logic       auto_ack, ack_man, req_q = 1'b0;
  logic [4:0] dly = '0;
  logic [2:0] exp_q[$];
  logic [2:0] e;
  int         checks = 0, errors = 0, rises = 0, r0;

  fast2slow_pulse_tx #(.SYNC_STAGES(3), .CNT_W(2)) dut (
    .clk_fast(clk), .rst_n(rst_n), .pulse_in(pulse_in), .ack_in(ack_in),
    .req_out(req_out), .busy(busy), .pending(pending), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) dly <= {dly[3:0], req_out};
  assign ack_in = auto_ack ? dly[4] : ack_man;

  always @(negedge clk) begin
    if (rst_n) begin
      if (req_out && !req_q) rises++;
      if (done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got done=1 pending=%0d req=%0d required no done", pending, req_out);
        end else begin
          e = exp_q.pop_front();
          if ({pending, req_out} !== e) begin
            errors++;
            $display("FAIL done_state: got pending=%0d req=%0d required pending=%0d req=%0d",
                     pending, req_out, e[2:1], e[0]);
          end
        end
      end
    end
    req_q = req_out;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic pulse_n(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_in = 1'b1;
      @(posedge clk) #1;
    end
    pulse_in = 1'b0;
  endtask

  task automatic drain(input string name, input int n_rises);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({name, "_drain"}, exp_q.size(), 0);
    chk({name, "_idle"}, busy, 0);
    chk({name, "_pending0"}, pending, 0);
    repeat (8) @(posedge clk);
    #1;
    chk({name, "_rises"}, rises - r0, n_rises);
  endtask

  task automatic wait_req_low();
    int n = 0;
    while (req_out && n < 50) begin
      @(posedge clk) #1;
      n++;
    end
    chk("req_fall_seen", req_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; pulse_in = 1'b0; auto_ack = 1'b1; ack_man = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req", req_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    #20 rst_n = 1'b1;
    @(posedge clk) #1;

    r0 = rises;
    exp_q.push_back({2'd0, 1'b0});
    pulse_n(1);
    chk("single_req", req_out, 1);
    chk("single_busy", busy, 1);
    drain("single", 1);

    r0 = rises;
    exp_q.push_back({2'd2, 1'b1});
    exp_q.push_back({2'd1, 1'b1});
    exp_q.push_back({2'd0, 1'b1});
    exp_q.push_back({2'd0, 1'b0});
    pulse_n(4);
    chk("burst_pending", pending, 3);
    drain("burst", 4);

    r0 = rises;
    auto_ack = 1'b0;
    exp_q.push_back({2'd2, 1'b1});
    exp_q.push_back({2'd1, 1'b1});
    exp_q.push_back({2'd0, 1'b1});
    exp_q.push_back({2'd0, 1'b0});
    pulse_n(5);
    chk("sat_pending", pending, 3);
    chk("sat_overflow", overflow, 1);
    chk("sat_req", req_out, 1);
    auto_ack = 1'b1;
    drain("sat", 4);
    chk("sat_overflow_sticky", overflow, 1);

    r0 = rises;
    auto_ack = 1'b0;
    exp_q.push_back({2'd2, 1'b1});
    exp_q.push_back({2'd1, 1'b1});
    exp_q.push_back({2'd0, 1'b1});
    exp_q.push_back({2'd0, 1'b0});
    pulse_n(3);
    chk("sim2_pending", pending, 2);
    ack_man = 1'b1;
    wait_req_low();
    ack_man = 1'b0;
    repeat (3) @(posedge clk);
    #1 pulse_in = 1'b1;
    @(posedge clk) #1 pulse_in = 1'b0;
    chk("sim2_done", done, 1);
    chk("sim2_req", req_out, 1);
    chk("sim2_pending_held", pending, 2);
    repeat (6) @(posedge clk);
    #1 auto_ack = 1'b1;
    drain("sim2", 4);

    r0 = rises;
    auto_ack = 1'b0;
    exp_q.push_back({2'd0, 1'b1});
    exp_q.push_back({2'd0, 1'b0});
    pulse_n(1);
    ack_man = 1'b1;
    wait_req_low();
    ack_man = 1'b0;
    repeat (3) @(posedge clk);
    #1 pulse_in = 1'b1;
    @(posedge clk) #1 pulse_in = 1'b0;
    chk("sim0_done", done, 1);
    chk("sim0_req", req_out, 1);
    chk("sim0_pending", pending, 0);
    repeat (6) @(posedge clk);
    #1 auto_ack = 1'b1;
    drain("sim0", 2);

    r0 = rises;
    auto_ack = 1'b0;
    ack_man = 1'b1;
    #2 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    pulse_n(1);
    chk("stale_pending", pending, 1);
    chk("stale_req", req_out, 0);
    chk("stale_busy", busy, 0);
    ack_man = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("stale_req_wait", req_out, 0);
    @(posedge clk) #1;
    chk("stale_req_rise", req_out, 1);
    chk("stale_pending_launch", pending, 0);
    exp_q.push_back({2'd0, 1'b0});
    auto_ack = 1'b1;
    drain("stale", 1);

    auto_ack = 1'b0;
    ack_man = 1'b0;
    pulse_n(5);
    chk("rstop_pending", pending, 3);
    chk("rstop_overflow", overflow, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstop_req", req_out, 0);
    chk("rstop_busy", busy, 0);
    chk("rstop_pending0", pending, 0);
    chk("rstop_overflow0", overflow, 0);
    chk("rstop_done", done, 0);
    #10 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rstop_idle", busy, 0);
    chk("rstop_req_after", req_out, 0);
    chk("final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
